// File: rtl/uart_reg_bridge_if.sv
// Bundles the RX byte stream, TX handshake and register-bus signals of uart_reg_bridge.
// master = the bridge itself, slave = the UART_IF / register-bus environment.
interface uart_reg_bridge_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_valid;
  logic                  i_rx_err;
  logic                  i_tx_ready;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_tx_valid;
  logic [ADDR_WIDTH-1:0] o_reg_addr;
  logic [DATA_WIDTH-1:0] o_reg_wdata;
  logic                  o_reg_wr;
  logic                  o_reg_rd;
  logic [DATA_WIDTH-1:0] i_reg_rdata;
  logic                  i_reg_rvalid;
  logic                  o_busy;

  modport master (
    input  i_rx_data, i_rx_valid, i_rx_err, i_tx_ready, i_reg_rdata, i_reg_rvalid,
    output o_tx_data, o_tx_valid, o_reg_addr, o_reg_wdata, o_reg_wr, o_reg_rd, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_rx_err, i_tx_ready, i_reg_rdata, i_reg_rvalid,
    input  o_tx_data, o_tx_valid, o_reg_addr, o_reg_wdata, o_reg_wr, o_reg_rd, o_busy
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// Host frame parser (A5 CMD ADDR [DATA]) driving single register writes/reads and a 5A STATUS PAYLOAD reply.
// Define UART_BRIDGE_CHKSUM_EN to add an XOR check byte to both host and response frames.
module uart_reg_bridge #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int BYTE_TIMEOUT = 50000,
  parameter int RD_TIMEOUT   = 256
) (
  input  logic               clk,
  input  logic               rst,
  uart_reg_bridge_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] SOF    = DATA_WIDTH'(8'hA5);
  localparam logic [DATA_WIDTH-1:0] RSP    = DATA_WIDTH'(8'h5A);
  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'h01);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'h02);
  localparam logic [DATA_WIDTH-1:0] ST_ERR = DATA_WIDTH'(8'hEE);
  localparam logic [DATA_WIDTH-1:0] ST_OK  = '0;

  localparam int TMR_MAX = (BYTE_TIMEOUT > RD_TIMEOUT) ? BYTE_TIMEOUT : RD_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] BYTE_LIM = TMR_W'(BYTE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RD_LIM   = TMR_W'(RD_TIMEOUT - 1);

`ifdef UART_BRIDGE_CHKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT,
    S_TX_HDR, S_TX_STAT, S_TX_PAY, S_TX_CHK
  } state_t;
  localparam state_t S_POST = S_CHK;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_EXEC, S_RDWAIT,
    S_TX_HDR, S_TX_STAT, S_TX_PAY
  } state_t;
  localparam state_t S_POST = S_EXEC;
`endif

  state_t                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] pay_q, pay_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
`ifdef UART_BRIDGE_CHKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;
`endif

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_byte;
  logic                  parse_st;
  logic [TMR_W-1:0]      tmr_inc;
  logic [DATA_WIDTH-1:0] status, payload;

  assign rx_data = bus.i_rx_data;
  assign rx_byte = bus.i_rx_valid && !bus.i_rx_err;
  assign tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
`ifdef UART_BRIDGE_CHKSUM_EN
  assign parse_st = state_q inside {S_CMD, S_ADDR, S_DATA, S_CHK};
`else
  assign parse_st = state_q inside {S_CMD, S_ADDR, S_DATA};
`endif

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pay_d   = pay_q;
    tmr_d   = tmr_q;
`ifdef UART_BRIDGE_CHKSUM_EN
    chk_d   = chk_q;
`endif
    if (parse_st) begin
      // RX error outranks a simultaneous byte; silence for BYTE_TIMEOUT cycles drops the frame
      if (bus.i_rx_err) begin
        state_d = S_IDLE;
      end else if (bus.i_rx_valid) begin
        tmr_d = '0;
`ifdef UART_BRIDGE_CHKSUM_EN
        chk_d = chk_q ^ rx_data;
`endif
        case (state_q)
          S_CMD: begin
            is_wr_d = (rx_data == CMD_WR);
            err_d   = (rx_data != CMD_WR) && (rx_data != CMD_RD);
            state_d = S_ADDR;
          end
          S_ADDR: begin
            addr_d = ADDR_WIDTH'(rx_data);
            if (err_q)        state_d = S_TX_HDR;
            else if (is_wr_q) state_d = S_DATA;
            else              state_d = S_POST;
          end
          S_DATA: begin
            wdata_d = rx_data;
            pay_d   = rx_data;
            state_d = S_POST;
          end
`ifdef UART_BRIDGE_CHKSUM_EN
          S_CHK: begin
            if (rx_data != chk_q) begin
              err_d   = 1'b1;
              state_d = S_TX_HDR;
            end else begin
              state_d = S_EXEC;
            end
          end
`endif
          default: state_d = S_IDLE;
        endcase
      end else if (tmr_q >= BYTE_LIM) begin
        state_d = S_IDLE;
      end else begin
        tmr_d = tmr_inc;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte && (rx_data == SOF)) begin
            state_d = S_CMD;
            err_d   = 1'b0;
            tmr_d   = '0;
`ifdef UART_BRIDGE_CHKSUM_EN
            chk_d   = SOF;
`endif
          end
        end
        S_EXEC: begin
          tmr_d = '0;
          if (is_wr_q) begin
            state_d = S_TX_HDR;
          end else if (bus.i_reg_rvalid) begin
            pay_d   = bus.i_reg_rdata;
            state_d = S_TX_HDR;
          end else begin
            state_d = S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          if (bus.i_reg_rvalid) begin
            pay_d   = bus.i_reg_rdata;
            state_d = S_TX_HDR;
          end else if (tmr_q >= RD_LIM) begin
            err_d   = 1'b1;
            state_d = S_TX_HDR;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        S_TX_HDR:  if (bus.i_tx_ready) state_d = S_TX_STAT;
        S_TX_STAT: if (bus.i_tx_ready) state_d = S_TX_PAY;
`ifdef UART_BRIDGE_CHKSUM_EN
        S_TX_PAY:  if (bus.i_tx_ready) state_d = S_TX_CHK;
        S_TX_CHK:  if (bus.i_tx_ready) state_d = S_IDLE;
`else
        S_TX_PAY:  if (bus.i_tx_ready) state_d = S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pay_q   <= '0;
      tmr_q   <= '0;
`ifdef UART_BRIDGE_CHKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pay_q   <= pay_d;
      tmr_q   <= tmr_d;
`ifdef UART_BRIDGE_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // TX bytes are a pure function of state, so data holds while a byte is pending
  always_comb begin
    status         = err_q ? ST_ERR : ST_OK;
    payload        = err_q ? '0 : pay_q;
    bus.o_tx_valid = 1'b0;
    bus.o_tx_data  = '0;
    case (state_q)
      S_TX_HDR:  begin bus.o_tx_valid = 1'b1; bus.o_tx_data = RSP;     end
      S_TX_STAT: begin bus.o_tx_valid = 1'b1; bus.o_tx_data = status;  end
      S_TX_PAY:  begin bus.o_tx_valid = 1'b1; bus.o_tx_data = payload; end
`ifdef UART_BRIDGE_CHKSUM_EN
      S_TX_CHK:  begin bus.o_tx_valid = 1'b1; bus.o_tx_data = RSP ^ status ^ payload; end
`endif
      default: ;
    endcase
  end

  assign bus.o_reg_addr  = addr_q;
  assign bus.o_reg_wdata = wdata_q;
  assign bus.o_reg_wr    = (state_q == S_EXEC) && is_wr_q;
  assign bus.o_reg_rd    = (state_q == S_EXEC) && !is_wr_q;
  assign bus.o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: transaction-level expectation queues plus literal response checks.
// Honours UART_BRIDGE_CHKSUM_EN for frame construction and response length.
module tb_uart_reg_bridge;
  localparam int BT = 40;
  localparam int RT = 16;
`ifdef UART_BRIDGE_CHKSUM_EN
  localparam int RSP_LEN = 4;
`else
  localparam int RSP_LEN = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_reg_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bif ();

  uart_reg_bridge #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .BYTE_TIMEOUT(BT), .RD_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bif.master)
  );

  int n_cmp = 0, n_bad = 0;
  int n_wr = 0, n_rd = 0, n_tx = 0;
  int n_wr_exp = 0, n_rd_exp = 0, n_tx_exp = 0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic        tog_en = 1'b0, rdy_lvl = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---- behavioural model: what each host frame must produce ----
  task automatic push_rsp(input logic err, input logic [7:0] pay);
    logic [7:0] st, pl;
    st = err ? 8'hEE : 8'h00;
    pl = err ? 8'h00 : pay;
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(st);
    exp_tx.push_back(pl);
`ifdef UART_BRIDGE_CHKSUM_EN
    exp_tx.push_back(8'h5A ^ st ^ pl);
`endif
    n_tx_exp += RSP_LEN;
  endtask

  task automatic exp_write(input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    n_wr_exp++;
    push_rsp(1'b0, d);
  endtask

  task automatic exp_read(input logic [7:0] a, input logic ok, input logic [7:0] d);
    exp_rd.push_back(a);
    n_rd_exp++;
    push_rsp(!ok, d);
  endtask

  // ---- compare process ----
  logic       pend = 1'b0, last_xfer = 1'b0;
  logic [7:0] pend_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      last_xfer = 1'b0;
    end else begin
      if (last_xfer) chk("tx_valid_drop", bif.o_tx_valid, 1'b0);
      if (pend) begin
        chk("tx_hold_valid", bif.o_tx_valid, 1'b1);
        chk("tx_hold_data", bif.o_tx_data, pend_data);
      end
      if (bif.o_reg_wr) begin
        n_wr++;
        chk("wr_expected", exp_wr.size() > 0, 1'b1);
        if (exp_wr.size() > 0) chk("wr_addr_data", {bif.o_reg_addr, bif.o_reg_wdata}, exp_wr.pop_front());
      end
      if (bif.o_reg_rd) begin
        n_rd++;
        chk("rd_expected", exp_rd.size() > 0, 1'b1);
        if (exp_rd.size() > 0) chk("rd_addr", bif.o_reg_addr, exp_rd.pop_front());
      end
      last_xfer = 1'b0;
      if (bif.o_tx_valid && bif.i_tx_ready) begin
        n_tx++;
        tx_log.push_back(bif.o_tx_data);
        chk("tx_expected", exp_tx.size() > 0, 1'b1);
        if (exp_tx.size() > 0) chk("tx_byte", bif.o_tx_data, exp_tx.pop_front());
        last_xfer = (exp_tx.size() == 0);
      end
      pend = bif.o_tx_valid && !bif.i_tx_ready;
      pend_data = bif.o_tx_data;
    end
  end

  // tx_ready: fixed level, or toggling every 5 cycles
  initial begin
    int cnt = 0;
    logic ph = 1'b1;
    bif.i_tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tog_en) begin
        cnt++;
        if (cnt == 5) begin cnt = 0; ph = !ph; end
        bif.i_tx_ready = ph;
      end else begin
        bif.i_tx_ready = rdy_lvl;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
    bif.i_rx_data = b;
    bif.i_rx_valid = 1'b1;
    bif.i_rx_err = err;
    tick();
    bif.i_rx_valid = 1'b0;
    bif.i_rx_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] x;
    x = 8'hA5 ^ cmd ^ a;
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(a);
    if (cmd == 8'h01) begin
      send_byte(d);
      x = x ^ d;
    end
`ifdef UART_BRIDGE_CHKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bif.o_busy) break;
    end
    chk("idle_reached", bif.o_busy, 1'b0);
    tick();
  endtask

  task automatic wait_rd(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.o_reg_rd) begin seen = 1'b1; break; end
    end
    chk("rd_strobe_seen", seen, 1'b1);
  endtask

  task automatic chk_log(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    chk("rsp_len", tx_log.size(), RSP_LEN);
    if (tx_log.size() >= 3) chk("rsp_bytes", {tx_log[0], tx_log[1], tx_log[2]}, {b0, b1, b2});
    tx_log.delete();
  endtask

  task automatic chk_counts();
    chk("wr_count", n_wr, n_wr_exp);
    chk("rd_count", n_rd, n_rd_exp);
    chk("tx_count", n_tx, n_tx_exp);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, {bif.o_tx_data, bif.o_tx_valid, bif.o_reg_addr, bif.o_reg_wdata,
               bif.o_reg_wr, bif.o_reg_rd, bif.o_busy}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   cyc;
    rst = 1'b1;
    bif.i_rx_data = '0; bif.i_rx_valid = 1'b0; bif.i_rx_err = 1'b0;
    bif.i_reg_rdata = '0; bif.i_reg_rvalid = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset_outputs");
    rst = 1'b0;
    tick();
    chk("busy_after_reset", bif.o_busy, 1'b0);

    // write A5 01 10 3C
    exp_write(8'h10, 8'h3C);
    send_frame(8'h01, 8'h10, 8'h3C);
    wait_idle(100);
    chk_log(8'h5A, 8'h00, 8'h3C);
    chk_counts();

    // read A5 02 22, rvalid 3 cycles after o_reg_rd
    exp_read(8'h22, 1'b1, 8'h7E);
    send_frame(8'h02, 8'h22, 8'h00);
    wait_rd(seen);
    tick();
    repeat (2) tick();
    bif.i_reg_rdata = 8'h7E; bif.i_reg_rvalid = 1'b1;
    tick();
    bif.i_reg_rvalid = 1'b0;
    wait_idle(100);
    chk_log(8'h5A, 8'h00, 8'h7E);
    chk_counts();

    // read with rvalid in the same cycle as o_reg_rd
    exp_read(8'h23, 1'b1, 8'hC4);
    send_frame(8'h02, 8'h23, 8'h00);
    bif.i_reg_rdata = 8'hC4; bif.i_reg_rvalid = 1'b1;
    tick();
    bif.i_reg_rvalid = 1'b0;
    wait_idle(100);
    chk_log(8'h5A, 8'h00, 8'hC4);

    // read timeout
    exp_read(8'h30, 1'b0, 8'h00);
    send_frame(8'h02, 8'h30, 8'h00);
    wait_rd(seen);
    cyc = 0;
    while (!bif.o_tx_valid && cyc < 4 * RT) begin
      @(negedge clk);
      cyc++;
    end
    chk("rd_timeout_window", (cyc >= RT) && (cyc <= RT + 2), 1'b1);
    wait_idle(100);
    chk_log(8'h5A, 8'hEE, 8'h00);
    chk_counts();

    // bad command, then stray byte in IDLE
    push_rsp(1'b1, 8'h00);
    send_frame(8'h07, 8'h10, 8'h00);
    wait_idle(100);
    chk_log(8'h5A, 8'hEE, 8'h00);
    send_byte(8'h33);
    tick();
    chk("idle_stray_byte", bif.o_busy, 1'b0);
    chk_counts();

    // inter-byte gap just under the limit keeps the frame alive
    exp_write(8'h12, 8'h81);
    send_byte(8'hA5); send_byte(8'h01);
    repeat (BT - 5) tick();
    send_byte(8'h12); send_byte(8'h81);
`ifdef UART_BRIDGE_CHKSUM_EN
    send_byte(8'hA5 ^ 8'h01 ^ 8'h12 ^ 8'h81);
`endif
    wait_idle(100);
    chk_log(8'h5A, 8'h00, 8'h81);

    // byte timeout abandons the frame
    send_byte(8'hA5); send_byte(8'h01);
    repeat (BT + 5) tick();
    chk("timeout_to_idle", bif.o_busy, 1'b0);
    send_byte(8'h10); send_byte(8'h3C);
    repeat (3) tick();
    chk_counts();

    // rx error after CMD, and rx error coincident with a byte
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h00, 1'b1);
    chk("rx_err_abort", bif.o_busy, 1'b0);
    send_byte(8'h10); send_byte(8'h3C);
    send_byte(8'hA5);
    send_byte(8'h01, 1'b1);
    chk("rx_err_priority", bif.o_busy, 1'b0);
    send_byte(8'h10); send_byte(8'h3C);
    repeat (3) tick();
    chk_counts();

    // toggling tx_ready with RX noise during the response
    tog_en = 1'b1;
    exp_write(8'h44, 8'h99);
    send_frame(8'h01, 8'h44, 8'h99);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55);
    wait_idle(300);
    tog_en = 1'b0;
    chk_log(8'h5A, 8'h00, 8'h99);
    chk_counts();

    // reset asserted while a response byte is pending
    rdy_lvl = 1'b0;
    tick();
    exp_write(8'h55, 8'hAA);
    send_frame(8'h01, 8'h55, 8'hAA);
    repeat (3) tick();
    chk("tx_pending_before_rst", bif.o_tx_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("outputs_in_rst");
    n_tx_exp -= exp_tx.size();
    exp_tx.delete();
    tx_log.delete();
    tick();
    rst = 1'b0;
    rdy_lvl = 1'b1;
    tick();
    exp_write(8'h66, 8'h01);
    send_frame(8'h01, 8'h66, 8'h01);
    wait_idle(100);
    chk_log(8'h5A, 8'h00, 8'h01);
    chk_counts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
Byte-level command controller that sits between the UART_IF user interface and a simple register bus. It parses host frames from the RX byte stream and issues single register writes/reads. It sequences the TX side to return an acknowledge or read data. It is the host-debug path to on-chip configuration registers (sensor/LCD/HDMI control blocks).

Parameters:
ADDR_WIDTH, 8, register address width; one address byte is used, upper bits are zero-extended.
DATA_WIDTH, 8, register data width; must equal the UART_IF DATA_WIDTH.
BYTE_TIMEOUT, 50000, clk cycles allowed between consecutive RX bytes of one frame.
RD_TIMEOUT, 256, clk cycles allowed for i_reg_rvalid after o_reg_rd.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_rx_data  in  DATA_WIDTH  byte from UART_IF o_user_rx_data
i_rx_valid  in  1  one-cycle strobe, RX byte valid
i_rx_err  in  1  one-cycle strobe, RX parity/stop error
i_tx_ready  in  1  UART_IF o_user_tx_ready
o_tx_data  out  DATA_WIDTH  byte to transmit
o_tx_valid  out  1  TX request; held until accepted
o_reg_addr  out  ADDR_WIDTH  register address
o_reg_wdata  out  DATA_WIDTH  write data
o_reg_wr  out  1  one-cycle write strobe
o_reg_rd  out  1  one-cycle read strobe
i_reg_rdata  in  DATA_WIDTH  read data, sampled on i_reg_rvalid
i_reg_rvalid  in  1  read data valid
o_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; timers cleared. Reset asserted mid-frame abandons the frame; no partial bus strobe or TX byte is produced.
- Host frame: 0xA5, CMD, ADDR, then DATA only when CMD=0x01 (write). CMD=0x02 is read.
- Response frame: 0x5A, STATUS, PAYLOAD.
  - Write OK: STATUS=0x00, PAYLOAD=written data.
  - Read OK: STATUS=0x00, PAYLOAD=read data.
  - Error: STATUS=0xEE, PAYLOAD=0x00.
- FSM states: IDLE -> CMD -> ADDR -> [DATA] -> EXEC -> [RDWAIT] -> TX_HDR -> TX_STAT -> TX_PAY -> IDLE.
- IDLE: a byte other than 0xA5 is discarded silently.
- CMD: a value other than 0x01/0x02 sets the error flag. The parser still consumes ADDR, then jumps to TX_HDR. No bus access occurs.
- EXEC write: o_reg_wr high for exactly 1 cycle, with o_reg_addr and o_reg_wdata stable that cycle. Next state is TX_HDR.
- EXEC read: o_reg_rd high for exactly 1 cycle, then RDWAIT. RDWAIT latches i_reg_rdata on i_reg_rvalid and goes to TX_HDR.
  - RD_TIMEOUT cycles without rvalid: error response.
  - i_reg_rvalid in the same cycle as o_reg_rd is accepted.
- TX handshake: a byte transfers when o_tx_valid && i_tx_ready. o_tx_data must not change while o_tx_valid is high and not yet accepted. o_tx_valid deasserts the cycle after the final byte is accepted.
- RX during EXEC/RDWAIT/TX states: bytes are ignored (no queueing). The host must wait for the response.
- i_rx_err at any parse state (CMD..DATA): abort to IDLE, no response. In IDLE it is ignored.
- Byte timeout: the counter resets on each accepted byte and runs in CMD..DATA. Reaching BYTE_TIMEOUT returns to IDLE, no response.
- Simultaneous i_rx_valid and i_rx_err: the error takes priority.
- Counters saturate; they never wrap.

Optional Feature:
UART_BRIDGE_CHKSUM_EN
- Defined:
  - Host frame gains a trailing CHK byte = XOR of all preceding frame bytes, including 0xA5.
  - A mismatch produces an error response and no bus access.
  - The response gains a trailing XOR byte over 0x5A, STATUS and PAYLOAD (states CHK and TX_CHK are added).
- Undefined: frames are exactly as above and no checksum logic exists.

Test Plan:
- RX A5 01 10 3C, tx_ready=1 -> one o_reg_wr with addr 0x10, wdata 0x3C; TX 5A 00 3C; o_busy returns to 0.
- RX A5 02 22; rvalid 3 cycles after o_reg_rd with rdata 0x7E -> one o_reg_rd at addr 0x22; TX 5A 00 7E.
- Read with rvalid never asserted -> after RD_TIMEOUT, TX 5A EE 00; FSM returns to IDLE.
- RX A5 07 10 -> no bus strobe; TX 5A EE 00. RX 33 in IDLE -> no activity.
- RX A5 01, then a gap > BYTE_TIMEOUT, then 10 3C -> no strobe, no TX. Repeat with i_rx_err after 01 -> same result.
- tx_ready toggling 0/1 every 5 cycles during a response -> o_tx_data stable while pending; bytes arrive in order. Assert rst mid-TX -> all outputs 0 immediately.
